// File: rtl/uart_loader_if.sv
// Byte-stream, BRAM port-A and status signals of the UART boot loader.
// The master side feeds bytes and observes; the slave side is the loader.
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  bram_ena;
    logic                  bram_wea;
    logic [ADDR_WIDTH-1:0] bram_addra;
    logic [DATA_WIDTH-1:0] bram_dina;
    logic                  cpu_rst_n;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  busy;
    logic                  error;

    modport master (
        output rx_data, rx_valid,
        input  bram_ena, bram_wea, bram_addra, bram_dina,
        input  cpu_rst_n, tx_data, tx_start, busy, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output bram_ena, bram_wea, bram_addra, bram_dina,
        output cpu_rst_n, tx_data, tx_start, busy, error
    );
endinterface

// File: rtl/uart_loader.sv
// UART boot loader: parses 0x55 / N(16b) / N big-endian words into BRAM,
// acks with the payload XOR, then releases the CPU from reset.
module uart_loader #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_loader_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {SYNC, LEN_HI, LEN_LO, DATA, ACK, DONE} state_t;

    state_t                r_state, w_next;
    logic [15:0]           r_len, r_wcnt;
    logic [1:0]            r_bcnt;
    logic [23:0]           r_asm;
    logic [7:0]            r_csum;
    logic [CW-1:0]         r_idle;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_dina;
    logic [7:0]            r_tx_data;
    logic                  r_tx_start;
    logic                  r_error;

    logic                  w_sync, w_in_frame, w_timeout, w_word_done, w_last, w_enter_hi;
    logic [7:0]            w_csum_nxt;

    assign w_sync      = bus.rx_valid && (bus.rx_data == 8'h55);
    assign w_in_frame  = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA);
    // A byte landing on the last allowed cycle still counts, so only a silent cycle times out.
    assign w_timeout   = w_in_frame && !bus.rx_valid && (r_idle == CW'(TIMEOUT_CYCLES - 1));
    assign w_word_done = (r_state == DATA) && bus.rx_valid && (r_bcnt == 2'd3);
    assign w_last      = w_word_done && (r_wcnt == r_len - 16'd1);
    assign w_enter_hi  = ((r_state == SYNC) || (r_state == DONE)) && w_sync;
    assign w_csum_nxt  = ((r_state == DATA) && bus.rx_valid) ? (r_csum ^ bus.rx_data) : r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SYNC;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SYNC:   if (w_sync) w_next = LEN_HI;
            LEN_HI: if (w_timeout) w_next = SYNC;
                    else if (bus.rx_valid) w_next = LEN_LO;
            LEN_LO: if (w_timeout) w_next = SYNC;
                    else if (bus.rx_valid)
                        w_next = ({r_len[15:8], bus.rx_data} != 16'd0) ? DATA : ACK;
            DATA:   if (w_timeout) w_next = SYNC;
                    else if (w_last) w_next = ACK;
            ACK:    w_next = DONE;
            DONE:   if (w_sync) w_next = LEN_HI;
            default: w_next = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_wcnt     <= '0;
            r_bcnt     <= '0;
            r_asm      <= '0;
            r_csum     <= '0;
            r_idle     <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_dina     <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_we       <= w_word_done;
            r_tx_start <= (w_next == ACK);
            if (w_next == ACK) r_tx_data <= w_csum_nxt;
            if (r_we) r_addr <= r_addr + ADDR_WIDTH'(1);
            if (w_in_frame) r_idle <= bus.rx_valid ? '0 : r_idle + CW'(1);
            else            r_idle <= '0;
            if (w_timeout) r_error <= 1'b1;
            case (r_state)
                LEN_HI: if (bus.rx_valid) r_len[15:8] <= bus.rx_data;
                LEN_LO: if (bus.rx_valid) r_len[7:0]  <= bus.rx_data;
                DATA: if (bus.rx_valid) begin
                    r_asm  <= {r_asm[15:0], bus.rx_data};
                    r_bcnt <= r_bcnt + 2'd1;
                    r_csum <= w_csum_nxt;
                    if (r_bcnt == 2'd3) begin
                        r_dina <= {r_asm, bus.rx_data};
                        r_wcnt <= r_wcnt + 16'd1;
                    end
                end
                default: ;
            endcase
            if (w_enter_hi) begin
                r_addr  <= '0;
                r_csum  <= '0;
                r_error <= 1'b0;
                r_wcnt  <= '0;
                r_bcnt  <= '0;
            end
        end
    end

    assign bus.bram_ena   = r_we;
    assign bus.bram_wea   = r_we;
    assign bus.bram_addra = r_addr;
    assign bus.bram_dina  = r_dina;
    assign bus.cpu_rst_n  = (r_state == DONE);
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_start   = r_tx_start;
    assign bus.busy       = (r_state inside {LEN_HI, LEN_LO, DATA, ACK});
    assign bus.error      = r_error;
endmodule
